user_proj_timer_array: RTL and testbench

- Wishbone-slave array of CHANNELS independent programmable counter/timers.
- Sits in the user area as the successor to the single fixed counter example. It generalises channel count, width and count mode.
- Adds per-channel up/down counting, compare match with auto-reload or one-shot stop, sticky status with W1C, interrupt, LA gating and square-wave outputs on user IO.

---
 rtl/user_proj_timer_array.sv | 183 ++++++++++++++++++
 tb/tb_user_proj_timer_array.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_proj_timer_array.sv
// Wishbone-slave array of programmable up/down counter/timers with compare match,
// auto-reload or one-shot stop, sticky W1C status, interrupt, LA gating and square-wave pads.
module user_proj_timer_array #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned IO_BASE      = 8,
  parameter int unsigned MPRJ_IO_PADS = 38,
  parameter logic [31:0] BASE_ADR     = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [63:0]             la_data_in,
  input  logic [63:0]             la_oenb,
  output logic [63:0]             la_data_out,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb,
  output logic [2:0]              irq
);

  logic                ack_q;
  logic [31:0]         dat_q, dat_d;
  logic [4:0]          ctrl_q   [CHANNELS];
  logic [4:0]          ctrl_d   [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    reload_d [CHANNELS];
  logic [CHANNELS-1:0] match_q, match_d, tog_q, tog_d, pend;
  logic                irq_q;

  logic       req, hit, wr;
  logic [3:0] sel_ch;
  logic [1:0] sel_reg;

  assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit     = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign wr      = req & wbs_we_i & hit;
  assign sel_ch  = wbs_adr_i[7:4];
  assign sel_reg = wbs_adr_i[3:2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) r[8*k +: 8] = wdat[8*k +: 8];
    end
    return r;
  endfunction

  always_comb begin : next_state
    logic        en_eff, term, ch_wr;
    logic [31:0] cur, nxt;
    for (int c = 0; c < CHANNELS; c++) begin
      en_eff = la_oenb[c] ? ctrl_q[c][0] : la_data_in[c];
      term   = ctrl_q[c][1] ? (count_q[c] == '0) : (count_q[c] == reload_q[c]);
      ch_wr  = wr && (sel_ch == 4'(c));

      count_d[c]  = count_q[c];
      reload_d[c] = reload_q[c];
      ctrl_d[c]   = ctrl_q[c];
      match_d[c]  = match_q[c];
      tog_d[c]    = tog_q[c];

      if (en_eff) begin
        if (term) begin
          tog_d[c] = ~tog_q[c];
          if (ctrl_q[c][2]) count_d[c] = ctrl_q[c][1] ? reload_q[c] : '0;
          else              ctrl_d[c][0] = 1'b0;
        end else begin
          count_d[c] = ctrl_q[c][1] ? count_q[c] - WIDTH'(1) : count_q[c] + WIDTH'(1);
        end
      end

      // Bus writes are applied last so they win over count steps and one-shot stops.
      cur = '0;
      nxt = '0;
      if (ch_wr) begin
        unique case (sel_reg)
          2'd0: begin
            cur[4:0]  = ctrl_q[c];
            nxt       = merge(cur, wbs_dat_i, wbs_sel_i);
            ctrl_d[c] = nxt[4:0];
          end
          2'd1: begin
            cur[WIDTH-1:0] = count_q[c];
            nxt            = merge(cur, wbs_dat_i, wbs_sel_i);
            count_d[c]     = nxt[WIDTH-1:0];
          end
          2'd2: begin
            cur[WIDTH-1:0] = reload_q[c];
            nxt            = merge(cur, wbs_dat_i, wbs_sel_i);
            reload_d[c]    = nxt[WIDTH-1:0];
          end
          default: begin
            if (wbs_sel_i[0] && wbs_dat_i[0]) match_d[c] = 1'b0;
          end
        endcase
      end
      if (en_eff && term) match_d[c] = 1'b1;

      pend[c] = match_q[c] & ctrl_q[c][3];
    end
  end

  always_comb begin : read_mux
    dat_d = '0;
    if (req && !wbs_we_i && hit) begin
      if (sel_ch == 4'hF) begin
        if (sel_reg == 2'd0) dat_d[CHANNELS-1:0] = pend;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (sel_ch == 4'(c)) begin
            unique case (sel_reg)
              2'd0:    dat_d[4:0]       = ctrl_q[c];
              2'd1:    dat_d[WIDTH-1:0] = count_q[c];
              2'd2:    dat_d[WIDTH-1:0] = reload_q[c];
              default: dat_d[0]         = match_q[c];
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      match_q <= '0;
      tog_q   <= '0;
      irq_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ctrl_q[c]   <= '0;
        count_q[c]  <= '0;
        reload_q[c] <= '0;
      end
    end else begin
      ack_q   <= req;
      dat_q   <= dat_d;
      match_q <= match_d;
      tog_q   <= tog_d;
      irq_q   <= |pend;
      for (int c = 0; c < CHANNELS; c++) begin
        ctrl_q[c]   <= ctrl_d[c];
        count_q[c]  <= count_d[c];
        reload_q[c] <= reload_d[c];
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = {2'b00, irq_q};

  always_comb begin : outputs
    logic [31:0] cnt0;
    cnt0             = '0;
    cnt0[WIDTH-1:0]  = count_q[0];
    la_data_out      = '0;
    la_data_out[CHANNELS-1:0] = match_q;
    la_data_out[47:32]        = cnt0[15:0];
    io_out = '0;
    io_oeb = '1;
    for (int c = 0; c < CHANNELS; c++) begin
      io_out[IO_BASE+c] = tog_q[c] & ctrl_q[c][4];
      io_oeb[IO_BASE+c] = 1'b0;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{io_in, la_data_in, la_oenb, wbs_adr_i[1:0], wbs_dat_i};

endmodule

// File: tb/tb_user_proj_timer_array.sv
// Directed self-checking bench for user_proj_timer_array (4 channels, 32-bit, IO_BASE 8).
module tb_user_proj_timer_array;
  localparam int PADS = 38;
  localparam int IOB  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stb, cyc, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            ack;
  logic [31:0]     rdat;
  logic [63:0]     la_in, la_oenb, la_out;
  logic [PADS-1:0] io_in, io_out, io_oeb;
  logic [2:0]      irq;

  int errors = 0;
  int checks = 0;

  user_proj_timer_array #(
    .CHANNELS(4), .WIDTH(32), .IO_BASE(IOB), .MPRJ_IO_PADS(PADS), .BASE_ADR(32'h3000_0000)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_out),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] ra(input int ch, input int r);
    return 32'h3000_0000 | 32'(ch << 4) | 32'(r << 2);
  endfunction

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic got_ack);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    @(negedge clk);
    got_ack = ack;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(negedge clk);
    d = rdat;
    stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0]     d;
    logic [PADS-1:0] exp_oeb;
    exp_oeb = '1;
    exp_oeb[IOB+3:IOB] = 4'b0000;
    checks++; if (io_oeb !== exp_oeb) begin errors++;
      $display("FAIL reset_io_oeb got=%h exp=%h", io_oeb, exp_oeb); end
    checks++; if (irq !== 3'b000) begin errors++;
      $display("FAIL reset_irq got=%b exp=000", irq); end
    checks++; if (la_out !== 64'h0) begin errors++;
      $display("FAIL reset_la got=%h exp=0", la_out); end
    checks++; if (io_out !== '0) begin errors++;
      $display("FAIL reset_io_out got=%h exp=0", io_out); end
    checks++; if (ack !== 1'b0 || rdat !== 32'h0) begin errors++;
      $display("FAIL reset_bus ack=%b dat=%h exp 0/0", ack, rdat); end
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 4; r++) begin
        wb_read(ra(ch, r), d);
        checks++; if (d !== 32'h0) begin errors++;
          $display("FAIL reset_reg ch=%0d r=%0d got=%h exp=0", ch, r, d); end
      end
    end
    wb_read(ra(15, 0), d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL reset_pend got=%h exp=0", d); end
  endtask

  task automatic test_up_auto;
    logic a;
    logic [15:0] exp_cnt;
    wb_write(ra(0, 2), 32'd5, 4'hF, a);
    wb_write(ra(0, 0), 32'h0D, 4'hF, a);
    for (int i = 0; i < 8; i++) begin
      exp_cnt = (i <= 5) ? 16'(i) : 16'(i - 6);
      checks++; if (la_out[47:32] !== exp_cnt) begin errors++;
        $display("FAIL up_count i=%0d got=%0d exp=%0d", i, la_out[47:32], exp_cnt); end
      checks++; if (la_out[0] !== (i >= 6)) begin errors++;
        $display("FAIL up_match i=%0d got=%b exp=%b", i, la_out[0], i >= 6); end
      checks++; if (irq[0] !== (i >= 7)) begin errors++;
        $display("FAIL up_irq i=%0d got=%b exp=%b", i, irq[0], i >= 7); end
      @(negedge clk);
    end
    wb_write(ra(0, 0), 32'h0C, 4'hF, a);
    wb_write(ra(0, 3), 32'h1, 4'hF, a);
    checks++; if (la_out[0] !== 1'b0 || irq[0] !== 1'b1) begin errors++;
      $display("FAIL w1c_edge match=%b irq=%b exp 0/1", la_out[0], irq[0]); end
    @(negedge clk);
    checks++; if (irq[0] !== 1'b0) begin errors++;
      $display("FAIL w1c_irq got=%b exp=0", irq[0]); end
  endtask

  task automatic test_down_oneshot;
    logic a;
    logic [31:0] d;
    wb_write(ra(1, 1), 32'd3, 4'hF, a);
    wb_write(ra(1, 0), 32'h03, 4'hF, a);
    repeat (10) @(negedge clk);
    wb_read(ra(1, 1), d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL down_count got=%h exp=0", d); end
    wb_read(ra(1, 0), d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL down_ctrl got=%h exp=2", d); end
    wb_read(ra(1, 3), d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL down_status got=%h exp=1", d); end
    wb_read(ra(15, 0), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL down_pend got=%h exp=0", d); end
    checks++; if (irq !== 3'b000 || la_out[3:0] !== 4'b0010) begin errors++;
      $display("FAIL down_out irq=%b la=%b exp 000/0010", irq, la_out[3:0]); end
  endtask

  task automatic test_square_la;
    logic a;
    logic [31:0] d;
    wb_write(ra(2, 2), 32'd1, 4'hF, a);
    wb_write(ra(2, 0), 32'h15, 4'hF, a);
    for (int i = 0; i < 8; i++) begin
      checks++; if (io_out[IOB+2] !== 1'((i / 2) % 2)) begin errors++;
        $display("FAIL sq_out i=%0d got=%b exp=%b", i, io_out[IOB+2], 1'((i / 2) % 2)); end
      @(negedge clk);
    end
    @(negedge clk);
    la_oenb[2] = 1'b0;
    la_in[2]   = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (io_out[IOB+2] !== 1'b0) begin errors++;
      $display("FAIL la_freeze_out got=%b exp=0", io_out[IOB+2]); end
    wb_read(ra(2, 1), d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL la_freeze_cnt got=%h exp=1", d); end
    la_in[2] = 1'b1;
    @(negedge clk);
    checks++; if (io_out[IOB+2] !== 1'b1) begin errors++;
      $display("FAIL la_resume got=%b exp=1", io_out[IOB+2]); end
    la_oenb = '1;
    la_in   = '0;
    wb_write(ra(2, 0), 32'h0, 4'hF, a);
    wb_write(ra(2, 1), 32'h77, 4'hF, a);
  endtask

  task automatic test_bytes_and_decode;
    logic a;
    logic [31:0] d;
    wb_write(ra(3, 2), 32'hAABBCCDD, 4'b0010, a);
    wb_read(ra(3, 2), d);
    checks++; if (d !== 32'h0000CC00) begin errors++;
      $display("FAIL byte_write got=%h exp=0000cc00", d); end
    wb_write(ra(14, 1), 32'h55, 4'hF, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL unmapped_ack got=%b exp=1", a); end
    wb_read(ra(14, 1), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", d); end
    wb_read(ra(2, 1), d);
    checks++; if (d !== 32'h77) begin errors++; $display("FAIL unmapped_alias got=%h exp=77", d); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = ra(3, 2); sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (ack !== (i % 2 == 0)) begin errors++;
        $display("FAIL b2b_ack i=%0d got=%b exp=%b", i, ack, i % 2 == 0); end
      checks++; if (rdat !== ((i % 2 == 0) ? 32'h0000CC00 : 32'h0)) begin errors++;
        $display("FAIL b2b_dat i=%0d got=%h", i, rdat); end
    end
    stb = 1'b0; cyc = 1'b0;
  endtask

  task automatic test_collision;
    logic a;
    wb_write(ra(0, 0), 32'h0, 4'hF, a);
    wb_write(ra(0, 1), 32'h0, 4'hF, a);
    wb_write(ra(0, 2), 32'd3, 4'hF, a);
    wb_write(ra(0, 0), 32'h05, 4'hF, a);
    repeat (2) @(negedge clk);
    wb_write(ra(0, 1), 32'd100, 4'hF, a);
    checks++; if (la_out[47:32] !== 16'd100) begin errors++;
      $display("FAIL coll_count got=%0d exp=100", la_out[47:32]); end
    checks++; if (la_out[0] !== 1'b1) begin errors++;
      $display("FAIL coll_match got=%b exp=1", la_out[0]); end
    wb_write(ra(0, 0), 32'h0, 4'hF, a);
    wb_write(ra(0, 3), 32'h1, 4'hF, a);
    checks++; if (la_out[0] !== 1'b0) begin errors++;
      $display("FAIL coll_clear got=%b exp=0", la_out[0]); end
    wb_write(ra(0, 1), 32'h0, 4'hF, a);
    wb_write(ra(0, 0), 32'h05, 4'hF, a);
    repeat (2) @(negedge clk);
    wb_write(ra(0, 3), 32'h1, 4'hF, a);
    checks++; if (la_out[0] !== 1'b1 || la_out[47:32] !== 16'd0) begin errors++;
      $display("FAIL coll_w1c match=%b cnt=%0d exp 1/0", la_out[0], la_out[47:32]); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] d;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (la_out !== 64'h0 || io_out !== '0 || ack !== 1'b0) begin errors++;
      $display("FAIL midop_reset la=%h io=%h ack=%b exp 0", la_out, io_out, ack); end
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(ra(0, 0), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midop_ctrl got=%h exp=0", d); end
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; wdat = '0; la_in = '0; la_oenb = '1; io_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_up_auto;
    test_down_oneshot;
    test_square_la;
    test_bytes_and_decode;
    test_back_to_back;
    test_collision;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
